// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DM_ADDR_LO = 2;
    localparam int DM_ADDR_HI = 13;

    // Take each byte lane from new_word where its enable is set, otherwise keep old_word.
    function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = old_word;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) m[8*k +: 8] = new_word[8*k +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin picker: on a tie the requester other than last wins.
module dm_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester data-memory access controller with round-robin arbitration
// and single-cycle byte-enabled read-merge-write stores.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_LO = DM_ADDR_LO,
    parameter int ADDR_HI = DM_ADDR_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  be0,
    input  logic [3:0]  be1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // The memory decodes only [ADDR_HI:ADDR_LO]; present the canonical word address.
    localparam logic [31:0] WORD_MASK =
        32'(((64'd1 << (ADDR_HI + 1)) - 64'd1) & ~((64'd1 << ADDR_LO) - 64'd1));

    state_t      state, state_nx;
    logic        last;
    logic        pick_valid, pick_winner;
    logic        win_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  rvalid_q;
    logic [31:0] rdata0_q, rdata1_q;

    dm_rr_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state    <= state_nx;
            rvalid_q <= '0;
            if (state == IDLE && pick_valid) begin
                last    <= pick_winner;
                win_q   <= pick_winner;
                we_q    <= pick_winner ? we1    : we0;
                addr_q  <= pick_winner ? addr1  : addr0;
                wdata_q <= pick_winner ? wdata1 : wdata0;
                be_q    <= pick_winner ? be1    : be0;
            end
            if (state == BUSY && !we_q) begin
                rvalid_q[win_q] <= 1'b1;
                if (win_q) rdata1_q <= mem_rdata;
                else       rdata0_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state)
            IDLE:    if (pick_valid) state_nx = BUSY;
            BUSY:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Reset masks every output so an in-flight store is never committed.
        if (!reset) begin
            rvalid0 = rvalid_q[0];
            rvalid1 = rvalid_q[1];
            rdata0  = rdata0_q;
            rdata1  = rdata1_q;
            if (state == BUSY) begin
                gnt0     = ~win_q;
                gnt1     = win_q;
                mem_addr = addr_q & WORD_MASK;
                if (we_q) begin
                    mem_we    = |be_q;
                    mem_wdata = merge_be(mem_rdata, wdata_q, be_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 4096x32 memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:4095];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;

    dm_arbiter #(.ADDR_LO(2), .ADDR_HI(13)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req[0]),
        .req1      (req[1]),
        .we0       (we[0]),
        .we1       (we[1]),
        .addr0     (addr[0]),
        .addr1     (addr[1]),
        .wdata0    (wdata[0]),
        .wdata1    (wdata[1]),
        .be0       (be[0]),
        .be1       (be[1]),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the gnt cycle.
    task automatic access(input string tag, input int p, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
        @(negedge clk);
        chk({tag, "_gnt"}, (p == 1) ? {31'b0, gnt1} : {31'b0, gnt0}, 32'd1);
        chk({tag, "_gnt_other"}, (p == 1) ? {31'b0, gnt0} : {31'b0, gnt1}, 32'd0);
        req[p] = 1'b0;
    endtask

    // Load, then check rvalid/rdata in the following cycle.
    task automatic load(input string tag, input int p, input logic [31:0] a, input logic [31:0] exp);
        access(tag, p, 1'b0, a, 32'h0, 4'h0);
        chk({tag, "_ld_we"}, {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, (p == 1) ? {31'b0, rvalid1} : {31'b0, rvalid0}, 32'd1);
        chk({tag, "_rdata"}, (p == 1) ? rdata1 : rdata0, exp);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_mem", {31'b0, mem_we} | mem_addr | mem_wdata, 32'd0);
        reset = 1'b0;

        // Full-word store then load back
        access("st10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("st10_we", {31'b0, mem_we}, 32'd1);
        chk("st10_addr", mem_addr, 32'h10);
        chk("st10_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("idle_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        chk("idle_mem", {31'b0, mem_we} | mem_addr | mem_wdata, 32'd0);
        load("ld10", 0, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("rvalid_pulse", {31'b0, rvalid0}, 32'd0);
        chk("rdata0_hold", rdata0, 32'hDEADBEEF);

        // Byte-enabled merge
        access("pre20", 0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        @(negedge clk);
        access("be20", 1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        chk("be20_we", {31'b0, mem_we}, 32'd1);
        chk("be20_wdata", mem_wdata, 32'h11BB33DD);
        @(negedge clk);
        load("ld20", 1, 32'h20, 32'h11BB33DD);
        chk("rdata0_keep", rdata0, 32'hDEADBEEF);
        @(negedge clk);

        // Tie from reset release: grants alternate 0,1,0
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_rdata0", rdata0, 32'd0);
        reset = 1'b0;
        req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20;
        @(negedge clk);
        chk("rr1_gnt", {30'b0, gnt1, gnt0}, 32'b01);
        chk("rr1_addr", mem_addr, 32'h10);
        @(negedge clk);
        chk("rr1_gap", {30'b0, gnt1, gnt0}, 32'b00);
        chk("rr1_rvalid", {30'b0, rvalid1, rvalid0}, 32'b01);
        chk("rr1_rdata", rdata0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rr2_gnt", {30'b0, gnt1, gnt0}, 32'b10);
        chk("rr2_addr", mem_addr, 32'h20);
        @(negedge clk);
        chk("rr2_rvalid", {30'b0, rvalid1, rvalid0}, 32'b10);
        chk("rr2_rdata", rdata1, 32'h11BB33DD);
        @(negedge clk);
        chk("rr3_gnt", {30'b0, gnt1, gnt0}, 32'b01);
        chk("rr3_addr", mem_addr, 32'h10);
        req = 2'b00;
        @(negedge clk);
        chk("rr3_rvalid", {31'b0, rvalid0}, 32'd1);

        // Store with be=0 is granted but never writes
        access("pre30", 0, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF);
        @(negedge clk);
        access("be0", 0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0);
        chk("be0_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        load("ld30", 1, 32'h30, 32'h5A5A5A5A);
        @(negedge clk);

        // Reset during BUSY store drops it
        access("pre40", 0, 1'b1, 32'h40, 32'h0, 4'hF);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF; be[1] = 4'hF;
        @(negedge clk);
        chk("inflight_gnt", {31'b0, gnt1}, 32'd1);
        chk("inflight_we", {31'b0, mem_we}, 32'd1);
        reset = 1'b1;
        req[1] = 1'b0;
        #1;
        chk("rstbusy_we", {31'b0, mem_we}, 32'd0);
        chk("rstbusy_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        chk("rstbusy_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_out", {28'b0, gnt1, gnt0, rvalid1, rvalid0}, 32'd0);
        @(negedge clk);
        chk("post_rst_out2", {28'b0, gnt1, gnt0, rvalid1, rvalid0}, 32'd0);
        load("ld40", 0, 32'h40, 32'h0);
        @(negedge clk);

        // Aliasing and misaligned low bits
        load("alias", 1, 32'h4010, 32'hDEADBEEF);
        @(negedge clk);
        load("misal", 0, 32'h13, 32'hDEADBEEF);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
